// File: rtl/snn_segment_capture.sv
// Segment/spike vector capture with channel-select output and a FWFT queue.
// Optional minimum-pulse hold on oSNN_OUT when built with SNN_STRETCH_EN.
module snn_segment_capture #(
  parameter int NUM_CH  = 7,
  parameter int DEPTH   = 16,
  parameter int SEL_W   = 3,
  parameter int THRESH  = 8,
  parameter int STRETCH = 8
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic [NUM_CH-1:0]          iSEG,
  input  logic                       iSET,
  input  logic [SEL_W-1:0]           iSEL,
  input  logic                       iPOP,
  input  logic                       iCLR_OVF,
  output logic                       oSNN_OUT,
  output logic [NUM_CH-1:0]          oDATA,
  output logic                       oVALID,
  output logic                       oFULL,
  output logic [$clog2(DEPTH+1)-1:0] oCOUNT,
  output logic                       oOVERFLOW,
  output logic                       oSAM_INT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [NUM_CH-1:0] mem_q [DEPTH];
  logic [NUM_CH-1:0] last_q, last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              int_q, int_d;
  logic              base_q, base_d;
  logic              push, pop;
  logic [NUM_CH-1:0] sel_shift;

  always_comb begin
    pop       = iPOP & valid_q;
    // A pop on the same edge frees the slot a full-queue push needs.
    push      = iSET & (~full_q | pop);
    sel_shift = last_q >> iSEL;
    base_d    = (int'(iSEL) < NUM_CH) ? sel_shift[0] : 1'b0;
    last_d    = iSET ? iSEG : last_q;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    valid_d = (count_d != '0);
    ovf_d   = (iSET & full_q & ~pop) | (ovf_q & ~iCLR_OVF);
    int_d   = (count_d >= CNT_W'(THRESH)) | ovf_d;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      int_q    <= 1'b0;
      base_q   <= 1'b0;
    end else begin
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      int_q    <= int_d;
      base_q   <= base_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET && push) begin
      mem_q[wr_ptr_q] <= iSEG;
    end
  end

`ifdef SNN_STRETCH_EN
  localparam int SW = $clog2(STRETCH+1);

  logic [SW-1:0] hold_q, hold_d;
  logic          prev_q, prev_d;

  always_comb begin
    prev_d = base_q;
    hold_d = hold_q;
    // Loaded one edge after base rises, so base plus hold spans STRETCH.
    if (base_q && !prev_q) begin
      hold_d = SW'(STRETCH-1);
    end else if (hold_q != '0) begin
      hold_d = hold_q - SW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      hold_q <= '0;
      prev_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      prev_q <= prev_d;
    end
  end

  assign oSNN_OUT = base_q | (hold_q != '0);
`else
  logic unused_stretch;
  assign unused_stretch = (STRETCH != 0);
  assign oSNN_OUT = base_q;
`endif

  assign oDATA     = mem_q[rd_ptr_q];
  assign oVALID    = valid_q;
  assign oFULL     = full_q;
  assign oCOUNT    = count_q;
  assign oOVERFLOW = ovf_q;
  assign oSAM_INT  = int_q;

endmodule

// File: tb/tb_snn_segment_capture.sv
// Bench for snn_segment_capture: directed scenarios plus random traffic
// checked each cycle against a queue-based reference model.
module tb_snn_segment_capture;

  localparam int NUM_CH  = 7;
  localparam int DEPTH   = 16;
  localparam int SEL_W   = 3;
  localparam int THRESH  = 8;
  localparam int STRETCH = 8;
  localparam int CW      = $clog2(DEPTH+1);

  logic              iCLK = 1'b0;
  logic              iRESET, iSET, iPOP, iCLR_OVF;
  logic [NUM_CH-1:0] iSEG;
  logic [SEL_W-1:0]  iSEL;
  logic              oSNN_OUT, oVALID, oFULL, oOVERFLOW, oSAM_INT;
  logic [NUM_CH-1:0] oDATA;
  logic [CW-1:0]     oCOUNT;

  always #5 iCLK = ~iCLK;

  snn_segment_capture #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .SEL_W(SEL_W),
    .THRESH(THRESH), .STRETCH(STRETCH)
  ) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSEG(iSEG), .iSET(iSET),
    .iSEL(iSEL), .iPOP(iPOP), .iCLR_OVF(iCLR_OVF),
    .oSNN_OUT(oSNN_OUT), .oDATA(oDATA), .oVALID(oVALID),
    .oFULL(oFULL), .oCOUNT(oCOUNT), .oOVERFLOW(oOVERFLOW),
    .oSAM_INT(oSAM_INT)
  );

  int checks = 0;
  int errors = 0;

  logic [NUM_CH-1:0] q[$];
  logic [NUM_CH-1:0] m_last;
  logic              m_base, m_ovf;
  int                m_since;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_out();
`ifdef SNN_STRETCH_EN
    return m_base | (m_since < STRETCH);
`else
    return m_base;
`endif
  endfunction

  task automatic model_edge();
    logic nb, dropped;
    if (iRESET) begin
      q.delete();
      m_last  = '0;
      m_base  = 1'b0;
      m_ovf   = 1'b0;
      m_since = STRETCH;
    end else begin
      nb = (int'(iSEL) < NUM_CH) ? m_last[iSEL] : 1'b0;
      if (nb && !m_base) m_since = 0;
      else if (m_since < STRETCH) m_since++;
      m_base  = nb;
      dropped = 1'b0;
      if (iPOP && q.size() > 0) void'(q.pop_front());
      if (iSET) begin
        if (q.size() < DEPTH) q.push_back(iSEG);
        else dropped = 1'b1;
        m_last = iSEG;
      end
      m_ovf = dropped | (m_ovf & ~iCLR_OVF);
    end
  endtask

  task automatic check_all();
    check("snn_out", 32'(oSNN_OUT), 32'(exp_out()));
    check("valid", 32'(oVALID), 32'(q.size() != 0));
    check("full", 32'(oFULL), 32'(q.size() == DEPTH));
    check("count", 32'(oCOUNT), 32'(q.size()));
    check("overflow", 32'(oOVERFLOW), 32'(m_ovf));
    check("sam_int", 32'(oSAM_INT), 32'((q.size() >= THRESH) | m_ovf));
    if (q.size() != 0) check("data", 32'(oDATA), 32'(q[0]));
  endtask

  task automatic drive(input logic set, input logic [NUM_CH-1:0] seg,
                       input logic [SEL_W-1:0] sel, input logic pop,
                       input logic clr, input logic rst);
    iSET = set; iSEG = seg; iSEL = sel;
    iPOP = pop; iCLR_OVF = clr; iRESET = rst;
    @(posedge iCLK);
    model_edge();
    @(negedge iCLK);
    check_all();
  endtask

  task automatic idle(input logic [SEL_W-1:0] sel);
    drive(1'b0, '0, sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int hi;
    int exp_hi;
    iSET = 0; iSEG = '0; iSEL = '0; iPOP = 0; iCLR_OVF = 0; iRESET = 1;
    @(negedge iCLK);
    do_reset();
    check("rst_count", 32'(oCOUNT), 32'd0);
    check("rst_int", 32'(oSAM_INT), 32'd0);

    drive(1'b1, 7'h05, 3'd2, 1'b0, 1'b0, 1'b0);
    check("tp1_count", 32'(oCOUNT), 32'd1);
    check("tp1_data", 32'(oDATA), 32'h05);
    check("tp1_int", 32'(oSAM_INT), 32'd0);
    idle(3'd2);
    check("tp1_out", 32'(oSNN_OUT), 32'd1);

    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, NUM_CH'(i), '0, 1'b0, 1'b0, 1'b0);
      check("thr_int", 32'(oSAM_INT), 32'(i == 8));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("thr_fall", 32'(oSAM_INT), 32'd0);
    check("thr_head", 32'(oDATA), 32'h02);

    do_reset();
    for (int i = 0; i < 17; i++)
      drive(1'b1, NUM_CH'(7'h20 + i), 3'd4, 1'b0, 1'b0, 1'b0);
    check("ovf_full", 32'(oFULL), 32'd1);
    check("ovf_count", 32'(oCOUNT), 32'(DEPTH));
    check("ovf_flag", 32'(oOVERFLOW), 32'd1);
    idle(3'd4);
    check("ovf_last", 32'(oSNN_OUT), 32'd1);
    drive(1'b0, '0, 3'd4, 1'b0, 1'b1, 1'b0);
    check("clr_flag", 32'(oOVERFLOW), 32'd0);
    check("clr_int", 32'(oSAM_INT), 32'd1);

    drive(1'b1, 7'h55, 3'd0, 1'b1, 1'b0, 1'b0);
    check("fpp_count", 32'(oCOUNT), 32'(DEPTH));
    check("fpp_ovf", 32'(oOVERFLOW), 32'd0);
    check("fpp_head", 32'(oDATA), 32'h21);
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("empty_pop", 32'(oCOUNT), 32'd0);

    for (int i = 0; i < 5; i++)
      drive(1'b1, 7'h7f, 3'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h7f, 3'd3, 1'b0, 1'b0, 1'b1);
    check("rst_mid_count", 32'(oCOUNT), 32'd0);
    check("rst_mid_valid", 32'(oVALID), 32'd0);
    check("rst_mid_out", 32'(oSNN_OUT), 32'd0);
    drive(1'b1, 7'h7f, 3'd7, 1'b0, 1'b0, 1'b0);
    idle(3'd7);
    idle(3'd7);
    check("sel_range", 32'(oSNN_OUT), 32'd0);

    do_reset();
    drive(1'b1, 7'h02, 3'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h00, 3'd1, 1'b0, 1'b0, 1'b0);
    hi = int'(oSNN_OUT);
    for (int i = 0; i < 15; i++) begin
      idle(3'd1);
      hi += int'(oSNN_OUT);
    end
`ifdef SNN_STRETCH_EN
    exp_hi = STRETCH;
`else
    exp_hi = 1;
`endif
    check("pulse_width", 32'(hi), 32'(exp_hi));

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 200) % 3;
      drive($urandom_range(99) < (phase == 0 ? 80 : (phase == 1 ? 50 : 20)),
            NUM_CH'($urandom), SEL_W'($urandom),
            $urandom_range(99) < (phase == 0 ? 20 : (phase == 1 ? 50 : 80)),
            $urandom_range(99) < 5,
            $urandom_range(999) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_segment_capture.md
Name: snn_segment_capture

Overview:
- Parametrised successor to the single-bit SNN output latch at the top level.
- Captures an NUM_CH-wide spike/segment vector from the user design on each iSET strobe and drives one software-selected channel onto oSNN_OUT.
- Queues every captured vector in a first-word-fall-through (FWFT) FIFO that the host drains; raises oSAM_INT at a fill threshold.
- Sits between MyDesign and the MKR pins / SAM interrupt, clocked by the 120 MHz system clock.

Parameters:
- NUM_CH, 7, channels per captured vector (1..32).
- DEPTH, 16, FIFO depth; power of 2, >=2.
- SEL_W, 3, width of the channel-select input.
- THRESH, 8, FIFO count at or above which oSAM_INT asserts (1..DEPTH).
- STRETCH, 8, minimum oSNN_OUT high time in cycles; used only with SNN_STRETCH_EN.

Ports:
- iCLK  in  1  system clock (wCLK120).
- iRESET  in  1  synchronous reset, active-high.
- iSEG  in  NUM_CH  segment/spike vector from the user design.
- iSET  in  1  capture strobe, sampled each rising edge.
- iSEL  in  SEL_W  channel routed to oSNN_OUT.
- iPOP  in  1  host pop of the FIFO head.
- iCLR_OVF  in  1  clears the sticky overflow flag.
- oSNN_OUT  out  1  selected channel of the last captured vector.
- oDATA  out  NUM_CH  FIFO head, valid while oVALID=1.
- oVALID  out  1  FIFO not empty.
- oFULL  out  1  FIFO count == DEPTH.
- oCOUNT  out  $clog2(DEPTH+1)  FIFO occupancy.
- oOVERFLOW  out  1  sticky flag: a capture was dropped.
- oSAM_INT  out  1  level interrupt to the SAM D21.

Behaviour:
- Reset: one clock; sync active-high. All outputs reset to 0; oCOUNT=0; FIFO pointers and last-capture register rLAST cleared.
  - iRESET asserted mid-operation discards FIFO contents on that edge.
  - iSET, iPOP and iCLR_OVF coincident with iRESET are ignored.
- Capture: when iSET=1 at an edge, rLAST <= iSEG and iSEG is pushed if not full.
  - Push when full: data dropped, rLAST still updated, oOVERFLOW <= 1.
  - oOVERFLOW holds until iCLR_OVF=1. If iCLR_OVF and an overflowing push coincide, the flag stays set.
- Selected output:
  - Base output is a register: base <= (iSEL < NUM_CH) ? rLAST[iSEL] : 0.
  - Latency: iSET at edge k -> rLAST at k -> oSNN_OUT valid after edge k+1.
  - A change on iSEL alone takes effect after 1 edge.
- FIFO (FWFT):
  - oDATA = mem[rd_ptr] whenever oVALID=1; value is don't-care when empty.
  - iPOP with oVALID=1 advances rd_ptr on that edge. iPOP when empty is ignored; no underflow flag.
  - Push and pop on the same edge:
    - not empty and not full: both occur, count unchanged;
    - full: pop and push both occur, count stays DEPTH, no overflow;
    - empty: push only, count becomes 1.
  - Pointers are log2(DEPTH) bits and wrap naturally. Count is tracked separately, so full and empty are unambiguous.
  - oFULL, oVALID and oCOUNT are registered and consistent with each other on every cycle.
- Interrupt: oSAM_INT <= (next count >= THRESH) | next overflow.
  - Asserts on the same edge the count reaches THRESH.
  - Deasserts on the edge the count drops below THRESH, provided overflow is clear.
- No other state machine. The block is a datapath plus FIFO counter, with a STRETCH counter when the optional feature is built.

Optional Feature:
- Macro: SNN_STRETCH_EN.
- Defined:
  - A rising edge of base loads a down-counter with STRETCH-1.
  - oSNN_OUT = base | (counter != 0), so every pulse is held high at least STRETCH cycles.
  - A new rising edge during the hold reloads the counter.
  - The counter is cleared by iRESET.
- Undefined: oSNN_OUT = base; no counter logic is synthesised.

Test Plan:
- Reset then iSEG=7'b0000101, iSEL=2, iSET=1 for 1 cycle -> oSNN_OUT=1 two edges later; oCOUNT=1; oVALID=1; oDATA=7'h05; oSAM_INT=0.
- Push 8 distinct vectors 0x01..0x08 -> oSAM_INT rises on the 8th push edge. Pop 1 -> oSAM_INT falls; oDATA=0x02.
- Push 17 vectors with no pops -> oFULL=1, oCOUNT=16, oOVERFLOW=1, 17th vector absent from the FIFO but present in rLAST. Then iCLR_OVF -> oOVERFLOW=0, oSAM_INT stays 1.
- FIFO full, iSET and iPOP on the same edge -> oCOUNT stays 16, oOVERFLOW stays 0, head advances by one, new vector at the tail. FIFO empty, iPOP alone -> no state change.
- Load 5 vectors, assert iRESET together with iSET -> next cycle oCOUNT=0, oVALID=0, oSNN_OUT=0; iSEL=7 (>=NUM_CH) after recapture -> oSNN_OUT=0.
- With SNN_STRETCH_EN and STRETCH=8: a 1-cycle iSET of bit iSEL=1 followed by a capture clearing it -> oSNN_OUT high exactly 8 cycles. Without the macro -> high 1 cycle.
